// File: rtl/reaction_timebase.sv
// rtl/reaction_timebase.sv - ms timebase, random/fixed waits and reaction capture
// One shared LFSR seeds the random wait; results feed the display path.
module reaction_timebase #(
    parameter int TICK_DIV     = 100_000,
    parameter int MS_W         = 14,
    parameter int RWAIT_MIN_MS = 1000,
    parameter int RND_W        = 12,
    parameter int WAIT5_MS     = 5000,
    parameter int LATE_MS      = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_rwait,
    input  logic            start_wait5,
    input  logic            time_clr,
    input  logic            time_en,
    input  logic            rs_en,
    output logic            rwait_done,
    output logic            wait5_done,
    output logic            time_late,
    output logic [MS_W-1:0] rt_ms,
    output logic [MS_W-1:0] result_ms,
    output logic [MS_W-1:0] best_ms,
    output logic            result_valid
);
    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]  MS_MAX  = {MS_W{1'b1}};
    localparam logic [MS_W-1:0]  LATE_T  = MS_W'(LATE_MS);
    localparam logic [MS_W-1:0]  W5_T    = MS_W'(WAIT5_MS);
    localparam logic [MS_W-1:0]  RMIN_T  = MS_W'(RWAIT_MIN_MS);

    generate
        if ((RWAIT_MIN_MS + (1 << RND_W) - 1 >= (1 << MS_W)) ||
            (WAIT5_MS >= (1 << MS_W)) || (LATE_MS >= (1 << MS_W))) begin : g_width_check
            $error("reaction_timebase: wait/late constants do not fit in MS_W bits");
        end
    endgenerate

    logic [15:0]      lfsr;
    logic [PRE_W-1:0] rt_pre;
    logic [PRE_W-1:0] wt_pre;
    logic [MS_W-1:0]  rt_ms_next;
    logic [MS_W-1:0]  rwait_cnt;
    logic [MS_W-1:0]  rwait_tgt;
    logic [MS_W-1:0]  w5_cnt;
    logic             rwait_prev;
    logic             w5_prev;
    logic             rs_prev;

    logic rt_tick;
    logic wt_run;
    logic wt_tick;
    logic rwait_rise;
    logic w5_rise;
    logic rs_rise;

    assign rt_tick    = time_en && (rt_pre == PRE_MAX);
    assign wt_run     = start_rwait || start_wait5;
    assign wt_tick    = wt_run && (wt_pre == PRE_MAX);
    assign rwait_rise = start_rwait && !rwait_prev;
    assign w5_rise    = start_wait5 && !w5_prev;
    assign rs_rise    = rs_en && !rs_prev;

    always_comb begin
        rt_ms_next = rt_ms;
        if (time_clr)
            rt_ms_next = '0;
        else if (rt_tick && (rt_ms != MS_MAX))
            rt_ms_next = rt_ms + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr         <= 16'hACE1;
            rt_pre       <= '0;
            wt_pre       <= '0;
            rt_ms        <= '0;
            time_late    <= 1'b0;
            rwait_prev   <= 1'b0;
            w5_prev      <= 1'b0;
            rs_prev      <= 1'b0;
            rwait_cnt    <= '0;
            rwait_tgt    <= '0;
            rwait_done   <= 1'b0;
            w5_cnt       <= '0;
            wait5_done   <= 1'b0;
            result_ms    <= '0;
            best_ms      <= MS_MAX;
            result_valid <= 1'b0;
        end else begin
            lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            rwait_prev <= start_rwait;
            w5_prev    <= start_wait5;
            rs_prev    <= rs_en;

            if (time_clr)
                rt_pre <= '0;
            else if (time_en)
                rt_pre <= (rt_pre == PRE_MAX) ? '0 : rt_pre + 1'b1;

            if (!wt_run)
                wt_pre <= '0;
            else
                wt_pre <= (wt_pre == PRE_MAX) ? '0 : wt_pre + 1'b1;

            rt_ms     <= rt_ms_next;
            time_late <= !time_clr && (rt_ms_next >= LATE_T);

            // Counters park at their target so the done flag holds without wrapping.
            if (!start_rwait) begin
                rwait_cnt  <= '0;
                rwait_done <= 1'b0;
            end else if (rwait_rise) begin
                rwait_tgt  <= RMIN_T + MS_W'(lfsr[RND_W-1:0]);
                rwait_cnt  <= '0;
                rwait_done <= 1'b0;
            end else begin
                if (wt_tick && (rwait_cnt != rwait_tgt))
                    rwait_cnt <= rwait_cnt + 1'b1;
                rwait_done <= (rwait_cnt == rwait_tgt);
            end

            if (!start_wait5) begin
                w5_cnt     <= '0;
                wait5_done <= 1'b0;
            end else if (w5_rise) begin
                w5_cnt     <= '0;
                wait5_done <= 1'b0;
            end else begin
                if (wt_tick && (w5_cnt != W5_T))
                    w5_cnt <= w5_cnt + 1'b1;
                wait5_done <= (w5_cnt == W5_T);
            end

            if (rs_rise) begin
                result_ms    <= rt_ms;
                result_valid <= 1'b1;
                if (rt_ms < best_ms)
                    best_ms <= rt_ms;
            end else if (rwait_rise) begin
                result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reaction_timebase.sv
// tb/tb_reaction_timebase.sv - directed self-checking bench for reaction_timebase
module tb_reaction_timebase;
    localparam int MS_W = 14;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_rwait, start_wait5, time_clr, time_en, rs_en;
    logic            rwait_done, wait5_done, time_late, result_valid;
    logic [MS_W-1:0] rt_ms, result_ms, best_ms;

    int passed = 0;
    int total  = 0;
    logic [15:0] m;

    reaction_timebase #(
        .TICK_DIV(4), .MS_W(MS_W), .RWAIT_MIN_MS(5), .RND_W(3),
        .WAIT5_MS(8), .LATE_MS(10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_rwait(start_rwait), .start_wait5(start_wait5),
        .time_clr(time_clr), .time_en(time_en), .rs_en(rs_en),
        .rwait_done(rwait_done), .wait5_done(wait5_done), .time_late(time_late),
        .rt_ms(rt_ms), .result_ms(result_ms), .best_ms(best_ms),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // m mirrors the LFSR value the DUT will sample at the next rising edge.
    task automatic step_clk();
        @(posedge clk);
        if (rst_n) m = lfsr_next(m);
        else       m = 16'hACE1;
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        logic saw_early;
        int guard;
        rst_n = 1'b0; start_rwait = 1'b0; start_wait5 = 1'b0;
        time_clr = 1'b0; time_en = 1'b0; rs_en = 1'b0;
        m = 16'hACE1;
        @(negedge clk);
        steps(3);
        chk("rst_rt_ms", rt_ms, 0);
        chk("rst_best", best_ms, 16383);
        chk("rst_flags", {rwait_done, wait5_done, time_late, result_valid}, 0);
        chk("rst_result", result_ms, 0);
        rst_n = 1'b1;

        // random wait: rise when lfsr[2:0]==3 -> target 8 ms
        guard = 0;
        while (m[2:0] != 3'd3 && guard < 1000) begin
            step_clk();
            guard++;
        end
        start_rwait = 1'b1;
        steps(32);
        chk("rwait_early", rwait_done, 0);
        step_clk();
        chk("rwait_done", rwait_done, 1);
        start_rwait = 1'b0;
        step_clk();
        chk("rwait_drop", rwait_done, 0);

        // fixed 5 s wait, hold, reset while done, reset mid-wait
        start_wait5 = 1'b1;
        steps(32);
        chk("w5_early", wait5_done, 0);
        step_clk();
        chk("w5_done", wait5_done, 1);
        steps(3);
        chk("w5_hold", wait5_done, 1);
        rst_n = 1'b0;
        step_clk();
        chk("w5_rst_drop", wait5_done, 0);
        rst_n = 1'b1;
        steps(19);
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        saw_early = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step_clk();
            if (wait5_done) saw_early = 1'b1;
        end
        chk("w5_after_rst_early", saw_early, 0);
        step_clk();
        chk("w5_after_rst_done", wait5_done, 1);
        start_wait5 = 1'b0;
        step_clk();
        chk("w5_drop", wait5_done, 0);

        // reaction count and late flag
        time_en = 1'b1;
        steps(39);
        chk("rt_39", {rt_ms, time_late}, {14'd9, 1'b0});
        step_clk();
        chk("rt_40", {rt_ms, time_late}, {14'd10, 1'b1});
        time_clr = 1'b1;
        step_clk();
        chk("rt_clr", {rt_ms, time_late}, {14'd0, 1'b0});
        time_clr = 1'b0;

        // capture and best
        steps(24);
        chk("rt_24", rt_ms, 6);
        time_en = 1'b0; rs_en = 1'b1;
        step_clk();
        chk("cap1", {result_ms, best_ms, result_valid}, {14'd6, 14'd6, 1'b1});
        rs_en = 1'b0; time_clr = 1'b1;
        step_clk();
        time_clr = 1'b0; time_en = 1'b1;
        steps(36);
        time_en = 1'b0; rs_en = 1'b1;
        step_clk();
        chk("cap2", {result_ms, best_ms}, {14'd9, 14'd6});
        rs_en = 1'b0;

        // rs_en held high captures once; new round clears valid only
        time_clr = 1'b1;
        step_clk();
        time_clr = 1'b0; time_en = 1'b1;
        steps(8);
        rs_en = 1'b1;
        step_clk();
        chk("cap3", {result_ms, best_ms}, {14'd2, 14'd2});
        steps(10);
        chk("held_rt", rt_ms, 4);
        chk("held_nocap", result_ms, 2);
        time_en = 1'b0; start_rwait = 1'b1;
        step_clk();
        chk("round_valid", result_valid, 0);
        chk("round_keep", {result_ms, best_ms}, {14'd2, 14'd2});
        start_rwait = 1'b0; rs_en = 1'b0;
        step_clk();

        // saturation
        time_clr = 1'b1;
        step_clk();
        time_clr = 1'b0; time_en = 1'b1;
        steps(65531);
        chk("sat_pre", rt_ms, 16382);
        step_clk();
        chk("sat_max", rt_ms, 16383);
        steps(8);
        chk("sat_hold", {rt_ms, time_late}, {14'd16383, 1'b1});
        time_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
